// File: rtl/bp_me_mem_cmd_arbiter_2to1_if.sv
// bp_me_mem_cmd_arbiter_2to1_if
//   Bundles the requester-side and memory-side handshake signals of the
//   2:1 BedRock memory command arbiter.
//   The master modport is the arbiter's view. It drives the memory command and
//   response-routing outputs.
//   The slave modport is the surrounding harness's view. It drives the requester
//   commands, the response yumis and the memory-side inputs.
//   Signals:
//     req_cmd_i        per-requester command, slot i = [i*cmd_width_p +: cmd_width_p]
//     req_cmd_v_i      per-requester command valid
//     req_cmd_ready_o  per-requester command ready
//     req_resp_o       response data, broadcast to both requesters
//     req_resp_v_o     response valid, one-hot to the owning requester
//     req_resp_yumi_i  requester consumes response
//     mem_cmd_o        command to memory
//     mem_cmd_v_o      command valid to memory
//     mem_cmd_ready_i  memory ready for a command
//     mem_resp_i       response from memory
//     mem_resp_v_i     response valid from memory
//     mem_resp_yumi_o  response consumed
interface bp_me_mem_cmd_arbiter_2to1_if #(
  parameter int cmd_width_p  = 128,
  parameter int resp_width_p = 128
);
  logic [2*cmd_width_p-1:0] req_cmd_i;
  logic [1:0]               req_cmd_v_i;
  logic [1:0]               req_cmd_ready_o;
  logic [resp_width_p-1:0]  req_resp_o;
  logic [1:0]               req_resp_v_o;
  logic [1:0]               req_resp_yumi_i;
  logic [cmd_width_p-1:0]   mem_cmd_o;
  logic                     mem_cmd_v_o;
  logic                     mem_cmd_ready_i;
  logic [resp_width_p-1:0]  mem_resp_i;
  logic                     mem_resp_v_i;
  logic                     mem_resp_yumi_o;

  modport master (
    input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
    input  mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    output req_cmd_ready_o, req_resp_o, req_resp_v_o,
    output mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );

  modport slave (
    output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
    output mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    input  req_cmd_ready_o, req_resp_o, req_resp_v_o,
    input  mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );
endinterface

// File: rtl/bp_me_mem_cmd_arbiter_2to1.sv
// bp_me_mem_cmd_arbiter_2to1
//   Shares one BedRock memory command/response port between two cache-side
//   requesters. Requester 0 is the I$ UCE and requester 1 is the D$/aux UCE.
//   Commands are arbitrated round-robin, and a grant is held until memory accepts it.
//   Responses come back in command order. A requester-ID FIFO routes each one to
//   the requester that issued the matching command.
//   Ports:
//     clk_i    clock, rising edge
//     reset_i  asynchronous active-high reset
//     bus      handshake bundle, using the master modport
//     err_o    sticky protocol error, cleared only by reset
module bp_me_mem_cmd_arbiter_2to1 #(
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  bp_me_mem_cmd_arbiter_2to1_if.master bus,
  output logic err_o
);

  localparam int CntW = $clog2(max_outstanding_p + 1);
  localparam int PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(max_outstanding_p);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(max_outstanding_p - 1);

  typedef enum logic {StArb, StHold} arbState_e;

  arbState_e       r_state;
  logic            r_grant;
  logic            r_lastGrant;
  logic            r_fifo [max_outstanding_p];
  logic [PtrW-1:0] r_rdPtr;
  logic [PtrW-1:0] r_wrPtr;
  logic [CntW-1:0] r_count;
  logic            r_err;

  logic            w_full;
  logic            w_empty;
  logic            w_other;
  logic            w_arbGrant;
  logic            w_arbActive;
  logic            w_holdActive;
  logic            w_grant;
  logic            w_cmdV;
  logic [1:0]      w_cmdReady;
  logic            w_accept;
  logic            w_head;
  logic            w_respV;
  logic [1:0]      w_respVec;
  logic            w_pop;
  logic            w_errEvent;

  assign w_full  = (r_count == MaxCnt);
  assign w_empty = (r_count == '0);

  // Round-robin choice: prefer the requester that was not granted last time.
  // Fall back to the one that is valid.
  assign w_other    = ~r_lastGrant;
  assign w_arbGrant = bus.req_cmd_v_i[w_other] ? w_other : r_lastGrant;

  // A new grant is offered only from ARB with a free slot. The slot count is
  // the registered value, so a pop in this cycle does not free a slot until
  // the next cycle.
  assign w_arbActive  = (r_state == StArb) && !w_full && (|bus.req_cmd_v_i);
  assign w_holdActive = (r_state == StHold);
  assign w_grant      = w_holdActive ? r_grant : w_arbGrant;
  assign w_cmdV       = w_holdActive ? bus.req_cmd_v_i[r_grant] : w_arbActive;
  assign w_accept     = w_cmdV && bus.mem_cmd_ready_i;

  // Only the granted requester sees memory's ready.
  always_comb begin
    w_cmdReady = 2'b00;
    if (w_holdActive || w_arbActive) begin
      w_cmdReady[w_grant] = bus.mem_cmd_ready_i;
    end
  end

  // The command path is purely combinational, so an accept adds no latency.
  // All handshake outputs are forced low while reset is held.
  assign bus.mem_cmd_o       = w_grant ? bus.req_cmd_i[cmd_width_p +: cmd_width_p]
                                       : bus.req_cmd_i[0 +: cmd_width_p];
  assign bus.mem_cmd_v_o     = w_cmdV && !reset_i;
  assign bus.req_cmd_ready_o = reset_i ? 2'b00 : w_cmdReady;

  // Responses arrive in command order, so the FIFO head names the owner.
  assign w_head    = r_fifo[r_rdPtr];
  assign w_respV   = bus.mem_resp_v_i && !w_empty;
  assign w_respVec = w_respV ? (w_head ? 2'b10 : 2'b01) : 2'b00;
  assign w_pop     = w_respV && bus.req_resp_yumi_i[w_head];

  assign bus.req_resp_o      = bus.mem_resp_i;
  assign bus.req_resp_v_o    = reset_i ? 2'b00 : w_respVec;
  assign bus.mem_resp_yumi_o = w_pop && !reset_i;

  // Protocol errors are a response with nothing outstanding, or a yumi from a
  // requester that is not being offered a response.
  assign w_errEvent = (bus.mem_resp_v_i && w_empty) ||
                      (|(bus.req_resp_yumi_i & ~w_respVec));

  assign err_o = r_err;

  // Arbiter FSM, the ID FIFO and the outstanding counter.
  // Reset drops every pending command and ID.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= StArb;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) begin
        r_fifo[i] <= 1'b0;
      end
    end else begin
      unique case (r_state)
        StArb: begin
          if (w_arbActive) begin
            if (bus.mem_cmd_ready_i) begin
              r_lastGrant <= w_arbGrant;
            end else begin
              r_grant <= w_arbGrant;
              r_state <= StHold;
            end
          end
        end
        StHold: begin
          if (w_accept) begin
            r_lastGrant <= r_grant;
            r_state     <= StArb;
          end
        end
        default: r_state <= StArb;
      endcase

      if (w_accept) begin
        r_fifo[r_wrPtr] <= w_grant;
        r_wrPtr         <= (r_wrPtr == LastPtr) ? '0 : r_wrPtr + PtrW'(1);
      end

      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LastPtr) ? '0 : r_rdPtr + PtrW'(1);
      end

      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase

      if (w_errEvent) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
